// File: rtl/pipe_chain.sv
// pipe_chain: elastic N-stage valid/ready register chain. Each stage can be
// stalled (holds its content, downstream sees a bubble) or flushed (its next
// valid bit is forced low). Empty stages always accept unless stalled, so
// bubbles collapse. Saturating retire/bubble/flush counters feed the debug path.
module pipe_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stall_req,
  input  logic [STAGES-1:0]         flush_mask,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic [CNT_W-1:0]          bubble_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] keep_v;     // next valid before any flush is applied
  logic [STAGES-1:0] xfer;       // an item moves into stage i at this edge
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [STAGES:0]   en;         // en[i]: stage i updates (loads or empties)
  logic [4:0]        flush_n;    // live items killed this edge (<= 16)
  logic              retire_inc;
  logic              bubble_inc;
  logic [CNT_W-1:0]  retire_q;
  logic [CNT_W-1:0]  bubble_q;
  logic [CNT_W-1:0]  flush_q;

  // Saturating add; the increment never exceeds STAGES, so 5 bits suffice.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [4:0] inc);
    logic [CNT_W+4:0] sum;
    sum = {5'd0, a} + {{CNT_W{1'b0}}, inc};
    return (sum > {5'd0, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  // Enable chain rippling from the output back to the input.
  always_comb begin
    en = '0;
    en[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      en[i] = !stall_req[i] && (!v_q[i] || en[i+1]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             src_v;
      logic [WIDTH-1:0] src_d;
      if (gi == 0) begin : g_head
        assign src_v = in_valid;
        assign src_d = in_data;
      end else begin : g_body
        // A stalled upstream stage offers nothing, so this stage takes a bubble.
        assign src_v = v_q[gi-1] & ~stall_req[gi-1];
        assign src_d = d_q[gi-1];
      end
      assign xfer[gi]   = src_v & en[gi];
      assign keep_v[gi] = en[gi] ? xfer[gi] : v_q[gi];
      assign v_d[gi]    = keep_v[gi] & ~flush_mask[gi];
      assign d_d[gi]    = xfer[gi] ? src_d : d_q[gi];
      assign stage_data[gi*WIDTH +: WIDTH] = rst ? '0 : d_q[gi];
    end
  endgenerate

  // Count stages whose live content is discarded by the flush mask.
  always_comb begin
    flush_n = '0;
    for (int i = 0; i < STAGES; i++) begin
      flush_n = flush_n + 5'(flush_mask[i] & keep_v[i]);
    end
  end

  assign in_ready    = en[0] & ~rst;
  assign out_valid   = v_q[STAGES-1] & ~stall_req[STAGES-1] & ~rst;
  assign out_data    = rst ? '0 : d_q[STAGES-1];
  assign stage_valid = rst ? '0 : v_q;
  assign retire_inc  = out_valid & out_ready;
  assign bubble_inc  = out_ready & ~out_valid;
  assign retire_cnt  = rst ? '0 : retire_q;
  assign bubble_cnt  = rst ? '0 : bubble_q;
  assign flush_cnt   = rst ? '0 : flush_q;

  // Stage registers: valid bits and payloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
    end else begin
      v_q <= v_d;
      for (int i = 0; i < STAGES; i++) d_q[i] <= d_d[i];
    end
  end

  // Performance counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      retire_q <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      retire_q <= sat_add(retire_q, {4'd0, retire_inc});
      bubble_q <= sat_add(bubble_q, {4'd0, bubble_inc});
      flush_q  <= sat_add(flush_q, flush_n);
    end
  end

endmodule
